fp_normalize_pipe: RTL and testbench
====================================

FP_NORMALIZE_PIPE -- requirements
Module: fp_normalize_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent width.
REQ-002 Parameter FRAC_W, default 24, output mantissa width including hidden bit; input mantissa width is FRAC_W+1.
REQ-003 Parameter TAG_W, default 4, sideband tag width carried alongside each operand.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  operand present; in_ready  out  1  block accepts operand.
REQ-007 exp_in  in  EXP_W  biased exponent; frac_in  in  FRAC_W+1  unnormalised mantissa, MSB is carry bit; tag_in  in  TAG_W  sideband tag.
REQ-008 out_valid  out  1  result present; out_ready  in  1  consumer accepts result.
REQ-009 exp_out  out  EXP_W; frac_out  out  FRAC_W; tag_out  out  TAG_W; overflag, underflag, zeroflag  out  1 each.

Function
REQ-010 n SHALL be the leading-one position of frac_in counted from MSB (0..FRAC_W); mantissa SHALL be shifted left by n.
REQ-011 Result exponent e = exp_in + 1 - n, computed signed in EXP_W+2 bits.
REQ-012 frac_out SHALL be shifted mantissa bits [FRAC_W:1]; bit 0 is the round bit.
REQ-013 frac_in == 0: zeroflag=1, exp_out=0, frac_out=0, overflag=underflag=0.
REQ-014 e <= 0 (nonzero input): underflag=1, exp_out=0, frac_out=0.
REQ-015 e >= 2^EXP_W-1: overflag=1, exp_out all ones, frac_out=0.
REQ-016 Otherwise exp_out=e[EXP_W-1:0], all flags 0; flags are mutually exclusive.
REQ-017 Two-stage elastic pipeline: stage 1 registers leading-one count, mantissa, exponent, tag; stage 2 registers shift, exponent, flag results onto outputs.
REQ-018 Latency exactly 2 cycles from in_valid&in_ready to out_valid with out_ready held high; throughput one result per cycle, no bubbles.
REQ-019 Transfer occurs only on valid&ready; a stage advances when empty or when its downstream accepts.
REQ-020 in_ready = stage 1 empty OR stage 1 advancing in the same cycle (combinational from out_ready permitted).
REQ-021 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; pipeline holds at most 2 operands; results leave in acceptance order.
REQ-022 Simultaneous accept at input and output in a full pipeline SHALL lose and duplicate nothing.
REQ-023 tag_out SHALL equal the tag_in accepted with the same operand.

Reset
REQ-024 While rst=1: out_valid=0, both stage-valid bits=0, exp_out=0, frac_out=0, tag_out=0, all flags 0; in_ready=1 after reset releases.
REQ-025 rst asserted mid-operation SHALL discard all in-flight operands immediately with no partial output.

Configuration
REQ-026 Macro NORM_ROUND_EN defined: round-to-nearest-even on round bit in stage 2 (round bit 1, LSB 1 -> increment; round bit 1, LSB 0 -> keep); mantissa carry-out sets frac_out to 1000..0 and increments e before REQ-014..016 checks; latency unchanged.
REQ-027 Macro NORM_ROUND_EN undefined: round bit discarded (truncation).

Structure
REQ-028 Shared package fp_norm_pkg SHALL hold default EXP_W/FRAC_W constants and the flag-bundle typedef (over, under, zero).
REQ-029 Leading-one detector SHALL be sub-module lead_one_detect, parametrised on width, outputting count and all-zero flag.

Verification (EXP_W=8, FRAC_W=24, out_ready=1 unless stated)
REQ-030 frac_in=0x1000000, exp_in=127 -> 2 cycles later exp_out=128, frac_out=0x800000, flags 0; frac_in=0x0800000, exp_in=127 -> exp_out=127, frac_out=0x800000.
REQ-031 frac_in=0x0000001, exp_in=10 -> underflag=1, exp_out=0, frac_out=0; frac_in=0x1000000, exp_in=254 -> overflag=1, exp_out=0xFF, frac_out=0.
REQ-032 frac_in=0, exp_in=50 -> zeroflag=1, exp_out=0, frac_out=0, other flags 0.
REQ-033 out_ready=0 while offering 3 operands on consecutive cycles -> 2 accepted, in_ready=0, outputs stable; out_ready=1 -> 3 results in order with matching tags.
REQ-034 frac_in=0x1FFFFFF, exp_in=100 -> with NORM_ROUND_EN frac_out=0x800000, exp_out=102; without it frac_out=0xFFFFFF, exp_out=101.
REQ-035 rst pulsed with 2 operands in flight -> out_valid=0 same cycle, no stale result after release.

Source files
------------

// File: rtl/fp_normalize_pipe_pkg.sv
// fp_norm_pkg: default widths and shared types for the fp_normalize_pipe block.
// The flag bundle travels through stage 2 as one struct so the three flags stay grouped.
package fp_norm_pkg;

    localparam int EXP_W_DEF  = 8;
    localparam int FRAC_W_DEF = 24;
    localparam int TAG_W_DEF  = 4;

    typedef struct packed {
        logic over;
        logic under;
        logic zero;
    } norm_flags_t;

    // Bits needed to hold a leading-zero count of 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fp_normalize_pipe_if.sv
// fp_normalize_pipe_if: operand-in / result-out valid-ready bundle for fp_normalize_pipe.
// slave is the normaliser's view; master is the producer/consumer side.
interface fp_normalize_pipe_if
    import fp_norm_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [EXP_W-1:0]  exp_in;
    logic [FRAC_W:0]   frac_in;
    logic [TAG_W-1:0]  tag_in;

    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  exp_out;
    logic [FRAC_W-1:0] frac_out;
    logic [TAG_W-1:0]  tag_out;
    logic              overflag;
    logic              underflag;
    logic              zeroflag;

    modport slave (
        input  in_valid, exp_in, frac_in, tag_in, out_ready,
        output in_ready, out_valid, exp_out, frac_out, tag_out,
               overflag, underflag, zeroflag
    );

    modport master (
        output in_valid, exp_in, frac_in, tag_in, out_ready,
        input  in_ready, out_valid, exp_out, frac_out, tag_out,
               overflag, underflag, zeroflag
    );

endinterface

// File: rtl/fp_normalize_pipe_lead_one_detect.sv
// lead_one_detect: counts leading zeros of a W-bit word (0..W-1), returns W and zero_o
// when the word is all zeros.
module lead_one_detect
    import fp_norm_pkg::*;
#(
    parameter int W = FRAC_W_DEF + 1,
    localparam int CNT_W = cnt_width(W)
) (
    input  logic [W-1:0]     data_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    // NOTE: count_o gets its default before the loop, so every path assigns it and no
    // latch is inferred; later (higher) set bits overwrite, leaving the leading one.
    always_comb begin
        count_o = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                count_o = CNT_W'(W - 1 - i);
            end
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/fp_normalize_pipe.sv
// fp_normalize_pipe: two-stage elastic normaliser -- stage 1 holds the leading-one count,
// stage 2 shifts, adjusts the exponent and classifies. Define NORM_ROUND_EN for RNE rounding.
module fp_normalize_pipe
    import fp_norm_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input logic                clk,
    input logic                rst,
    fp_normalize_pipe_if.slave bus
);

    localparam int MW    = FRAC_W + 1;
    localparam int CNT_W = cnt_width(MW);
    localparam int SE_W  = EXP_W + 2;
    localparam logic [SE_W-1:0] EXP_MAX = SE_W'((1 << EXP_W) - 1);

    logic             s1_valid_q, s1_valid_d;
    logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
    logic [MW-1:0]    s1_frac_q,  s1_frac_d;
    logic [CNT_W-1:0] s1_cnt_q,   s1_cnt_d;
    logic             s1_zero_q,  s1_zero_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic              s2_valid_q, s2_valid_d;
    logic [EXP_W-1:0]  s2_exp_q,   s2_exp_d;
    logic [FRAC_W-1:0] s2_frac_q,  s2_frac_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
    norm_flags_t       s2_flags_q, s2_flags_d;

    logic             s1_ready;
    logic             s2_ready;
    logic [CNT_W-1:0] lod_cnt;
    logic             lod_zero;

    logic [MW-1:0]     nrm_shifted;
    logic [FRAC_W-1:0] nrm_mant;
    logic [SE_W-1:0]   nrm_exp;
    logic [EXP_W-1:0]  nrm_exp_out;
    logic [FRAC_W-1:0] nrm_frac_out;
    norm_flags_t       nrm_flags;

    // A stage can take new data when it is empty or its contents leave this cycle.
    assign s2_ready     = ~s2_valid_q | bus.out_ready;
    assign s1_ready     = ~s1_valid_q | s2_ready;
    assign bus.in_ready = s1_ready;

    lead_one_detect #(.W(MW)) u_lod (
        .data_i  (bus.frac_in),
        .count_o (lod_cnt),
        .zero_o  (lod_zero)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_exp_d   = s1_exp_q;
        s1_frac_d  = s1_frac_q;
        s1_cnt_d   = s1_cnt_q;
        s1_zero_d  = s1_zero_q;
        s1_tag_d   = s1_tag_q;
        if (s1_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_exp_d  = bus.exp_in;
                s1_frac_d = bus.frac_in;
                s1_cnt_d  = lod_cnt;
                s1_zero_d = lod_zero;
                s1_tag_d  = bus.tag_in;
            end
        end
    end

`ifdef NORM_ROUND_EN
    logic [MW-1:0] round_sum;
`else
    logic          round_unused;
    assign round_unused = nrm_shifted[0];
`endif

    // Exponent is carried in EXP_W+2 bits so the sign bit flags underflow directly.
    always_comb begin
        nrm_shifted = s1_frac_q << s1_cnt_q;
        nrm_mant    = nrm_shifted[MW-1:1];
        nrm_exp     = {2'b00, s1_exp_q} + SE_W'(1) - SE_W'(s1_cnt_q);
`ifdef NORM_ROUND_EN
        round_sum = {1'b0, nrm_mant} + MW'(1);
        if (nrm_shifted[0] && nrm_mant[0]) begin
            if (round_sum[MW-1]) begin
                nrm_mant = {1'b1, {(FRAC_W-1){1'b0}}};
                nrm_exp  = nrm_exp + SE_W'(1);
            end else begin
                nrm_mant = round_sum[FRAC_W-1:0];
            end
        end
`endif
        nrm_flags    = '0;
        nrm_exp_out  = '0;
        nrm_frac_out = '0;
        if (s1_zero_q) begin
            nrm_flags.zero = 1'b1;
        end else if (nrm_exp[SE_W-1] || (nrm_exp == '0)) begin
            nrm_flags.under = 1'b1;
        end else if (nrm_exp >= EXP_MAX) begin
            nrm_flags.over = 1'b1;
            nrm_exp_out    = '1;
        end else begin
            nrm_exp_out  = nrm_exp[EXP_W-1:0];
            nrm_frac_out = nrm_mant;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_exp_d   = s2_exp_q;
        s2_frac_d  = s2_frac_q;
        s2_tag_d   = s2_tag_q;
        s2_flags_d = s2_flags_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_exp_d   = nrm_exp_out;
                s2_frac_d  = nrm_frac_out;
                s2_tag_d   = s1_tag_q;
                s2_flags_d = nrm_flags;
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments only, so every flop samples
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_exp_q   <= '0;
            s1_frac_q  <= '0;
            s1_cnt_q   <= '0;
            s1_zero_q  <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_exp_q   <= '0;
            s2_frac_q  <= '0;
            s2_tag_q   <= '0;
            s2_flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_exp_q   <= s1_exp_d;
            s1_frac_q  <= s1_frac_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_zero_q  <= s1_zero_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_exp_q   <= s2_exp_d;
            s2_frac_q  <= s2_frac_d;
            s2_tag_q   <= s2_tag_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.exp_out   = s2_exp_q;
    assign bus.frac_out  = s2_frac_q;
    assign bus.tag_out   = s2_tag_q;
    assign bus.overflag  = s2_flags_q.over;
    assign bus.underflag = s2_flags_q.under;
    assign bus.zeroflag  = s2_flags_q.zero;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// tb_fp_normalize_pipe: directed and randomized checks of fp_normalize_pipe against an
// arithmetic reference model; honours NORM_ROUND_EN the same way as the design.
module tb_fp_normalize_pipe;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 24;
    localparam int TAG_W  = 4;

    typedef struct packed {
        logic              ov;
        logic              un;
        logic              z;
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        logic [TAG_W-1:0]  tag;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_normalize_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) bus ();

    fp_normalize_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    res_t exp_q[$];
    res_t got_q[$];
    int   acc_cyc_q[$];
    int   out_cyc_q[$];
    res_t last_seen;
    bit   last_in_rdy;
    bit   last_out_vld;
    bit   last_acc_in;

`ifdef NORM_ROUND_EN
    localparam logic [EXP_W-1:0]  E5  = 8'd102;
    localparam logic [FRAC_W-1:0] F5  = 24'h800000;
    localparam logic [FRAC_W-1:0] F14 = 24'h800002;
`else
    localparam logic [EXP_W-1:0]  E5  = 8'd101;
    localparam logic [FRAC_W-1:0] F5  = 24'hFFFFFF;
    localparam logic [FRAC_W-1:0] F14 = 24'h800001;
`endif

    logic [EXP_W-1:0] dir_ex [15] = '{8'd127, 8'd127, 8'd10, 8'd254, 8'd50, 8'd100, 8'd253,
        8'd0, 8'd0, 8'd254, 8'd255, 8'd60, 8'd30, 8'd20, 8'd20};
    logic [FRAC_W:0] dir_fr [15] = '{25'h1000000, 25'h0800000, 25'h0000001, 25'h1000000,
        25'h0000000, 25'h1FFFFFF, 25'h1000000, 25'h1000000, 25'h0800000, 25'h0800000,
        25'h0800000, 25'h0ABCDEF, 25'h0000003, 25'h1000001, 25'h1000003};
    logic [EXP_W-1:0] dir_we [15] = '{8'd128, 8'd127, 8'd0, 8'hFF, 8'd0, E5, 8'd254,
        8'd1, 8'd0, 8'd254, 8'hFF, 8'd60, 8'd8, 8'd21, 8'd21};
    logic [FRAC_W-1:0] dir_wf [15] = '{24'h800000, 24'h800000, 24'h0, 24'h0, 24'h0, F5,
        24'h800000, 24'h800000, 24'h0, 24'h800000, 24'h0, 24'hABCDEF, 24'hC00000,
        24'h800000, F14};
    logic [2:0] dir_fl [15] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000,
        3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};

    // Reference: scale the mantissa by two until its leading one reaches the top bit.
    function automatic res_t model(input logic [EXP_W-1:0] ex, input logic [FRAC_W:0] fr,
                                   input logic [TAG_W-1:0] tg);
        res_t            r;
        longint unsigned norm;
        longint unsigned mant;
        int              n;
        int              e;
        r     = '0;
        r.tag = tg;
        if (fr == '0) begin
            r.z = 1'b1;
            return r;
        end
        norm = 64'(fr);
        n    = 0;
        while (norm < (64'd1 << FRAC_W)) begin
            norm = norm * 2;
            n++;
        end
        mant = norm / 2;
        e    = int'(ex) + 1 - n;
`ifdef NORM_ROUND_EN
        if ((norm % 2 == 1) && (mant % 2 == 1)) mant = mant + 1;
        if (mant == (64'd1 << FRAC_W)) begin
            mant = 64'd1 << (FRAC_W - 1);
            e    = e + 1;
        end
`endif
        if (e <= 0) begin
            r.un = 1'b1;
        end else if (e >= (1 << EXP_W) - 1) begin
            r.ov = 1'b1;
            r.e  = '1;
        end else begin
            r.e = EXP_W'(e);
            r.f = FRAC_W'(mant);
        end
        return r;
    endfunction

    function automatic res_t observe();
        return {bus.overflag, bus.underflag, bus.zeroflag, bus.exp_out, bus.frac_out, bus.tag_out};
    endfunction

    task automatic set_in(input bit v, input logic [EXP_W-1:0] ex, input logic [FRAC_W:0] fr,
                          input logic [TAG_W-1:0] tg);
        bus.in_valid = v;
        bus.exp_in   = ex;
        bus.frac_in  = fr;
        bus.tag_in   = tg;
    endtask

    task automatic rand_in(input logic [TAG_W-1:0] tg);
        logic [FRAC_W:0] fr;
        fr = 25'($urandom) >> $urandom_range(0, 25);
        set_in(1'b1, 8'($urandom_range(0, 255)), fr, tg);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        acc_cyc_q.delete();
        out_cyc_q.delete();
    endtask

    // One clock: inputs are already set; sample handshakes at the falling edge.
    task automatic cycle();
        @(negedge clk);
        last_seen    = observe();
        last_in_rdy  = bus.in_ready;
        last_out_vld = bus.out_valid;
        last_acc_in  = bus.in_valid && bus.in_ready;
        if (last_acc_in) begin
            exp_q.push_back(model(bus.exp_in, bus.frac_in, bus.tag_in));
            acc_cyc_q.push_back(cyc);
        end
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(last_seen);
            out_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        set_in(1'b0, '0, '0, '0);
        #1;
        n_vec++;
        if ({bus.out_valid, observe()} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got valid=%b res=%h want all zero", bus.out_valid, observe());
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        n_vec++;
        if (last_in_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready got=%b want=1", last_in_rdy);
        end
        n_vec++;
        if (last_out_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid got=%b want=0", last_out_vld);
        end
        clear_sb();
    endtask

    task automatic test_directed();
        res_t want;
        clear_sb();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            set_in(1'b1, dir_ex[i], dir_fr[i], 4'(i));
            cycle();
            n_vec++;
            if (last_in_rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL directed_in_ready vec=%0d got=%b want=1", i, last_in_rdy);
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && got_q.size() < 15; i++) cycle();
        n_vec++;
        if (got_q.size() != 15) begin
            n_bad++;
            $display("FAIL directed_count got=%0d want=15", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 15; i++) begin
            want = {dir_fl[i], dir_we[i], dir_wf[i], 4'(i)};
            n_vec++;
            if (got_q[i] !== want) begin
                n_bad++;
                $display("FAIL directed_result vec=%0d got e=%h f=%h tag=%h ovz=%b%b%b want e=%h f=%h tag=%h ovz=%b%b%b",
                         i, got_q[i].e, got_q[i].f, got_q[i].tag, got_q[i].ov, got_q[i].un, got_q[i].z,
                         want.e, want.f, want.tag, want.ov, want.un, want.z);
            end
            n_vec++;
            if (out_cyc_q[i] - acc_cyc_q[i] != 2) begin
                n_bad++;
                $display("FAIL directed_latency vec=%0d got=%0d want=2", i, out_cyc_q[i] - acc_cyc_q[i]);
            end
        end
        clear_sb();
    endtask

    task automatic test_back_to_back();
        res_t want;
        int   stalls = 0;
        clear_sb();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_in(4'(i));
            cycle();
            if (!last_in_rdy) stalls++;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && got_q.size() < exp_q.size(); i++) cycle();
        n_vec++;
        if (stalls != 0 || got_q.size() != 40) begin
            n_bad++;
            $display("FAIL b2b_throughput got stalls=%0d results=%0d want stalls=0 results=40",
                     stalls, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            want = exp_q[i];
            n_vec++;
            if (got_q[i] !== want || out_cyc_q[i] - acc_cyc_q[i] != 2) begin
                n_bad++;
                $display("FAIL b2b_result idx=%0d got=%h lat=%0d want=%h lat=2",
                         i, got_q[i], out_cyc_q[i] - acc_cyc_q[i], want);
            end
        end
        clear_sb();
    endtask

    task automatic test_backpressure();
        res_t snap;
        clear_sb();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_in(4'(8 + i));
            if (i == 0) bus.frac_in = 25'h0400000;
            cycle();
        end
        n_vec++;
        if (exp_q.size() != 2 || last_in_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_fill got accepted=%0d in_ready=%b want accepted=2 in_ready=0",
                     exp_q.size(), last_in_rdy);
        end
        snap = last_seen;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if (last_seen !== snap || last_out_vld !== 1'b1 || last_in_rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cyc=%0d got res=%h v=%b rdy=%b want res=%h v=1 rdy=0",
                         i, last_seen, last_out_vld, last_in_rdy, snap);
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5 && exp_q.size() < 3; i++) cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && got_q.size() < 3; i++) cycle();
        n_vec++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            n_bad++;
            $display("FAIL bp_count got=%0d accepted=%0d want 3/3", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL bp_result idx=%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        clear_sb();
    endtask

    task automatic test_random();
        int   sent       = 0;
        bit   stall_prev = 1'b0;
        res_t prev_seen  = '0;
        clear_sb();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 4000 && (sent < 250 || got_q.size() < exp_q.size()); c++) begin
            if (!bus.in_valid && sent < 250 && $urandom_range(0, 9) < 7) rand_in(4'(sent));
            bus.out_ready = ($urandom_range(0, 9) < 6);
            cycle();
            if (stall_prev) begin
                n_vec++;
                if (last_out_vld !== 1'b1 || last_seen !== prev_seen) begin
                    n_bad++;
                    $display("FAIL rand_stable cyc=%0d got v=%b res=%h want v=1 res=%h",
                             cyc, last_out_vld, last_seen, prev_seen);
                end
            end
            stall_prev = last_out_vld && !bus.out_ready;
            prev_seen  = last_seen;
            if (last_acc_in) begin
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        n_vec++;
        if (got_q.size() != 250 || exp_q.size() != 250) begin
            n_bad++;
            $display("FAIL rand_count got=%0d accepted=%0d want 250/250", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL rand_result idx=%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        clear_sb();
    endtask

    task automatic test_midreset();
        clear_sb();
        bus.out_ready = 1'b1;
        set_in(1'b1, 8'd127, 25'h1000000, 4'hA);
        cycle();
        set_in(1'b1, 8'd90, 25'h0123456, 4'hB);
        cycle();
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_preload got out_valid=%b want=1", bus.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.out_valid, observe()} !== '0) begin
            n_bad++;
            $display("FAIL midrst_flush got valid=%b res=%h want all zero", bus.out_valid, observe());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_sb();
        repeat (5) cycle();
        n_vec++;
        if (got_q.size() != 0 || last_in_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_stale got results=%0d in_ready=%b want 0 results in_ready=1",
                     got_q.size(), last_in_rdy);
        end
        clear_sb();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
